// File: rtl/vx_mem_bus_responder.sv
// vx_mem_bus_responder
//
// Slave-side endpoint of the Vortex mem bus. It serves requests from a local
// single-port SRAM. Reads go through a LATENCY-stage pipeline into a response
// FIFO and come back tagged, in acceptance order. Writes produce no response.
// A credit counter covers reads in the pipeline plus FIFO entries, so the FIFO
// can never overflow.
//
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (req_ready is registered)
//   req_rw                  1 = write, 0 = read
//   req_addr                word address
//   req_byteen, req_data    write byte enables and write data
//   req_tag                 request tag, returned unmodified on rsp_tag
//   rsp_valid/rsp_ready     read response handshake
//   rsp_data, rsp_tag       read data and tag of the originating read
//   busy                    reads in flight or FIFO non-empty
//
// Optional feature (macro VX_MEM_RESPONDER_PERF_EN):
//   perf_reads, perf_writes, perf_stalls  44-bit wrapping event counters

module vx_mem_bus_responder #(
    parameter int unsigned DATA_SIZE      = 4,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TAG_WIDTH      = 8,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [8*DATA_SIZE-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,

    output logic                   rsp_valid,
    output logic [8*DATA_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready,

    output logic                   busy
`ifdef VX_MEM_RESPONDER_PERF_EN
    ,
    output logic [43:0]            perf_reads,
    output logic [43:0]            perf_writes,
    output logic [43:0]            perf_stalls
`endif
);

    localparam int unsigned DW    = 8 * DATA_SIZE;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = $clog2(RSP_FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic req_ready_q;
    logic req_fire;
    logic rd_fire;
    logic wr_fire;
    logic rsp_pop;

    assign req_fire = req_valid && req_ready_q;
    assign rd_fire  = req_fire && !req_rw;
    assign wr_fire  = req_fire && req_rw;
    assign rsp_pop  = rsp_valid && rsp_ready;

    // ------------------------------------------------------------------
    // SRAM (no reset; contents undefined until written)
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < int'(DATA_SIZE); b++) begin
                if (req_byteen[b]) begin
                    mem[req_addr][b*8 +: 8] <= req_data[b*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 captures the SRAM word at the accept edge,
    // later stages shift. Only the valid bits are reset.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] pipe_valid_q;
    logic [TAG_WIDTH-1:0] pipe_tag_q  [LATENCY];
    logic [DW-1:0]        pipe_data_q [LATENCY];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid_q <= '0;
        end else begin
            pipe_valid_q[0] <= rd_fire;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rd_fire) begin
            pipe_tag_q[0]  <= req_tag;
            pipe_data_q[0] <= mem[req_addr];
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            pipe_tag_q[i]  <= pipe_tag_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic                 fifo_enq;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     count_d;
    logic [DW-1:0]        fifo_data_q [RSP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0] fifo_tag_q  [RSP_FIFO_DEPTH];

    assign fifo_enq = pipe_valid_q[LATENCY-1];

    always_ff @(posedge clk) begin
        if (fifo_enq) begin
            fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
            fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
        end
    end

    always_comb begin
        count_d = count_q;
        case ({fifo_enq, rsp_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_enq) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rsp_valid = (count_q != '0);
    // Gate the storage so idle outputs read as zero rather than stale entries.
    assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_tag   = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;

    // ------------------------------------------------------------------
    // Credits: outstanding = reads in pipeline + FIFO entries.
    // req_ready is registered from the next-state count, so it never
    // depends combinationally on req_rw or rsp_ready.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({rd_fire, rsp_pop})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
            req_ready_q   <= 1'b1;
        end else begin
            outstanding_q <= outstanding_d;
            req_ready_q   <= (outstanding_d < CNT_W'(RSP_FIFO_DEPTH));
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = (outstanding_q != '0);

`ifdef VX_MEM_RESPONDER_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, wrapping modulo 2^44
    // ------------------------------------------------------------------
    logic [43:0] perf_reads_q;
    logic [43:0] perf_writes_q;
    logic [43:0] perf_stalls_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads_q  <= '0;
            perf_writes_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (rd_fire) begin
                perf_reads_q <= perf_reads_q + 44'd1;
            end
            if (wr_fire) begin
                perf_writes_q <= perf_writes_q + 44'd1;
            end
            if (req_valid && !req_ready_q) begin
                perf_stalls_q <= perf_stalls_q + 44'd1;
            end
        end
    end

    assign perf_reads  = perf_reads_q;
    assign perf_writes = perf_writes_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: doc/vx_mem_bus_responder.md
Name: vx_mem_bus_responder

Overview:
- Slave-side endpoint of the Vortex mem bus: receives requests from a mem-bus master (socket-level icache/dcache arbiter output, or a core port) and serves them from a local single-port SRAM.
- Reads return tagged responses in order, after a fixed pipeline latency, through a credit-limited response FIFO.
- Writes are absorbed silently; the mem-bus protocol returns no write response.
- Used as a scratchpad or memory model behind arbitrated buses.

Parameters:
- DATA_SIZE, 4, bytes per word; data width = 8*DATA_SIZE.
- ADDR_WIDTH, 10, word-address width; SRAM depth = 2^ADDR_WIDTH.
- TAG_WIDTH, 8, request/response tag width.
- LATENCY, 2, read pipeline stages (minimum 1).
- RSP_FIFO_DEPTH, 4, response FIFO entries (power of 2, minimum 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_byteen  in  DATA_SIZE  write byte enables.
- req_data  in  8*DATA_SIZE  write data.
- req_tag  in  TAG_WIDTH  request tag.
- req_ready  out  1  request accepted when valid&&ready.
- rsp_valid  out  1  read response valid.
- rsp_data  out  8*DATA_SIZE  read data.
- rsp_tag  out  TAG_WIDTH  tag of the originating read.
- rsp_ready  in  1  response consumed when valid&&ready.
- busy  out  1  reads in flight or FIFO non-empty.

Behaviour:
- Reset state: req_ready=1, rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0. Pipeline valid bits cleared, FIFO emptied, outstanding=0.
- Reset mid-operation: in-flight reads are dropped. SRAM contents are not reset and are undefined before the first write.
- Handshake: valid/ready. The master holds req_* stable while req_valid=1 && req_ready=0. rsp_* hold stable while rsp_valid=1 && rsp_ready=0.
- Write accept: SRAM word updated at the accept edge, bytes gated by req_byteen. No response, and outstanding is not incremented.
- Read accept: tag plus a valid bit enter a LATENCY-stage shift pipeline alongside the SRAM read. Data exits the last stage and is enqueued into the FIFO.
- Read latency: a read accepted at edge E0, with the FIFO empty, gives rsp_valid=1 in the cycle following edge E_LATENCY.
- Read-after-write: a write at edge Ek followed by a read of the same address at Ek+1 returns the new data.
- Credit counter: outstanding = reads in pipeline + FIFO entries, width clog2(RSP_FIFO_DEPTH)+1.
  - +1 on read accept, -1 on response pop; simultaneous accept and pop leaves it unchanged.
- req_ready = (outstanding < RSP_FIFO_DEPTH), registered.
  - It depends on neither req_rw nor rsp_ready combinationally.
  - Writes are blocked too while credits are exhausted.
- The FIFO never overflows because of the credit invariant. Enqueue and dequeue in the same cycle are legal at any occupancy, including full.
- Ordering: responses leave in strict acceptance order. Tags are passed through unmodified and never interpreted.
- busy = (outstanding != 0).
- Pointer wrap-around uses clog2(RSP_FIFO_DEPTH)-bit pointers plus the count; no special handling.

Optional Feature:
- Macro: VX_MEM_RESPONDER_PERF_EN.
- When defined, adds outputs:
  - perf_reads (44b): counts read accepts.
  - perf_writes (44b): counts write accepts.
  - perf_stalls (44b): counts cycles with req_valid=1 && req_ready=0.
- All three counters reset to 0 and wrap modulo 2^44.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Write then read: write addr 0x005 data 0xDEADBEEF byteen 0xF, then read addr 0x005 tag 0x3A. Expect rsp_valid exactly 2 cycles after the read accept, rsp_data=0xDEADBEEF, rsp_tag=0x3A.
- Byte enables: write 0x11223344 to addr 7, then write 0xAABBCCDD with byteen 0x5, then read. Expect 0x11BB33DD.
- Back-pressure and credits: hold rsp_ready=0 and issue 5 back-to-back reads, tags 1..5.
  - Expect 4 accepts, then req_ready=0 with the 5th held and busy=1.
  - Raise rsp_ready: expect tags 1,2,3,4,5 returned in order, with req_ready reasserting one cycle after the first pop.
- Streaming: rsp_ready=1 with 32 consecutive reads. Expect a sustained 1 accept per cycle and 32 in-order responses with matching data and tags.
- Reset mid-flight: 3 reads outstanding with rsp_ready=0, then assert reset low. Expect rsp_valid=0, busy=0 and req_ready=1 immediately, with no stale responses after release.
- Perf (VX_MEM_RESPONDER_PERF_EN): 3 writes, 4 reads, and 2 stall cycles. Expect perf_writes=3, perf_reads=4, perf_stalls=2.
